// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one uart_tx byte transmitter between NUM_REQ requesters.
//
// A round-robin arbiter picks one pending request, latches that requester's byte, pulses
// tx_data_en for one cycle and holds tx_data_in steady while uart_tx shifts the frame out.
// When uart_tx pulses tx_finish, the winner gets a one-cycle done pulse. The pointer then
// moves past the winner. An optional idle gap can be inserted before the next grant.
//
// Ports:
//   clk_in      system clock, rising edge
//   rst_n       synchronous reset, active low
//   req         per-requester level request, held until its grant pulse
//   req_data    byte of requester i on bits [8i+7:8i]
//   grant       one-hot pulse: byte of that requester accepted
//   done        one-hot pulse: byte of that requester fully transmitted
//   busy        high whenever the arbiter is not idle
//   tx_data_en  one-cycle start pulse to uart_tx
//   tx_data_in  byte to uart_tx, held from start until done
//   tx_finish   one-cycle completion pulse from uart_tx
//   tx_timeout  one-cycle pulse on watchdog abort
//
// Build option: define TX_TIMEOUT_EN to enable a watchdog. It aborts a frame after
// TIMEOUT_CYCLES cycles in WAIT_FIN. Without it, tx_timeout is constant 0.
module uart_tx_arbiter #(
  parameter int unsigned NUM_REQ        = 4,
  parameter int unsigned PTR_W          = 2,
  parameter int unsigned GAP_CYCLES     = 0,
  parameter int unsigned TIMEOUT_CYCLES = 2000000
) (
  input  logic                   clk_in,
  input  logic                   rst_n,
  input  logic [NUM_REQ-1:0]     req,
  input  logic [8*NUM_REQ-1:0]   req_data,
  output logic [NUM_REQ-1:0]     grant,
  output logic [NUM_REQ-1:0]     done,
  output logic                   busy,
  output logic                   tx_data_en,
  output logic [7:0]             tx_data_in,
  input  logic                   tx_finish,
  output logic                   tx_timeout
);

  typedef enum logic [1:0] {StIdle, StStart, StWaitFin, StGap} state_e;

  state_e           state;
  logic [PTR_W-1:0] rr_ptr;
  logic [PTR_W-1:0] owner;
  logic [7:0]       gap_cnt;

  // Round-robin pick: first search from rr_ptr upward. If nothing is found there, the
  // lowest set bit below rr_ptr is the wrapped winner.
  logic             win_found;
  logic [PTR_W-1:0] win;
  logic [7:0]       win_data;

  always_comb begin
    win_found = 1'b0;
    win       = '0;
    win_data  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!win_found && req[i] && (i >= int'(rr_ptr))) begin
        win_found = 1'b1;
        win       = PTR_W'(i);
        win_data  = req_data[8*i +: 8];
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!win_found && req[i]) begin
        win_found = 1'b1;
        win       = PTR_W'(i);
        win_data  = req_data[8*i +: 8];
      end
    end
  end

  logic [PTR_W-1:0]   next_ptr;
  logic [NUM_REQ-1:0] owner_oh;
  logic [NUM_REQ-1:0] win_oh;

  assign next_ptr = (owner == PTR_W'(NUM_REQ - 1)) ? '0 : owner + PTR_W'(1);
  assign owner_oh = {{(NUM_REQ-1){1'b0}}, 1'b1} << owner;
  assign win_oh   = {{(NUM_REQ-1){1'b0}}, 1'b1} << win;

  logic wd_hit;

`ifdef TX_TIMEOUT_EN
  localparam int unsigned WD_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [WD_W-1:0] wd_cnt;

  assign wd_hit = (state == StWaitFin) && (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1));

  // Held at zero outside WAIT_FIN, so every frame starts counting from zero.
  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      wd_cnt <= '0;
    end else if (state != StWaitFin) begin
      wd_cnt <= '0;
    end else if (!wd_hit) begin
      wd_cnt <= wd_cnt + WD_W'(1);
    end
  end
`else
  assign wd_hit = 1'b0;
`endif

  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      state      <= StIdle;
      rr_ptr     <= '0;
      owner      <= '0;
      gap_cnt    <= '0;
      tx_data_in <= 8'h00;
      grant      <= '0;
      done       <= '0;
      tx_data_en <= 1'b0;
      busy       <= 1'b0;
      tx_timeout <= 1'b0;
    end else begin
      grant      <= '0;
      done       <= '0;
      tx_data_en <= 1'b0;
      tx_timeout <= 1'b0;
      unique case (state)
        StIdle: begin
          if (win_found) begin
            owner      <= win;
            tx_data_in <= win_data;
            grant      <= win_oh;
            tx_data_en <= 1'b1;
            busy       <= 1'b1;
            state      <= StStart;
          end
        end
        StStart: state <= StWaitFin;
        StWaitFin: begin
          // A real tx_finish beats a watchdog hit in the same cycle.
          if (tx_finish || wd_hit) begin
            done       <= owner_oh;
            tx_timeout <= wd_hit & ~tx_finish;
            rr_ptr     <= next_ptr;
            gap_cnt    <= '0;
            if (GAP_CYCLES > 0) begin
              state <= StGap;
            end else begin
              state <= StIdle;
              busy  <= 1'b0;
            end
          end
        end
        StGap: begin
          // The done cycle is counted as gap_cnt=0. The arbiter then stays here for
          // GAP_CYCLES more cycles.
          if (gap_cnt == 8'(GAP_CYCLES)) begin
            state <= StIdle;
            busy  <= 1'b0;
          end else begin
            gap_cnt <= gap_cnt + 8'd1;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Randomized scoreboard bench for uart_tx_arbiter.
// A transaction-level model predicts, one cycle ahead, the full set of outputs.
// It uses the arbitration rules: round-robin from the pointer, grant one cycle after
// a pending request in an eligible idle cycle, and done one cycle after an accepted
// tx_finish. The next eligible cycle follows from the gap length. A monitor pops and
// compares each prediction.
module tb_uart_tx_arbiter;
  localparam int N    = 4;
  localparam int GAP  = 5;
  localparam int TMO  = 100;
  localparam int NCYC = 4000;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [N-1:0]   req = '0;
  logic [8*N-1:0] req_data = '0;
  logic           tx_finish = 1'b0;
  logic [N-1:0]   grant;
  logic [N-1:0]   done;
  logic           busy;
  logic           tx_data_en;
  logic [7:0]     tx_data_in;
  logic           tx_timeout;

  uart_tx_arbiter #(
    .NUM_REQ       (N),
    .PTR_W         (2),
    .GAP_CYCLES    (GAP),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk_in    (clk),
    .rst_n     (rst_n),
    .req       (req),
    .req_data  (req_data),
    .grant     (grant),
    .done      (done),
    .busy      (busy),
    .tx_data_en(tx_data_en),
    .tx_data_in(tx_data_in),
    .tx_finish (tx_finish),
    .tx_timeout(tx_timeout)
  );

  typedef struct {
    logic [N-1:0] grant;
    logic [N-1:0] done;
    logic         en;
    logic         busy;
    logic         tmo;
    logic         chk_data;
    logic [7:0]   data;
  } exp_t;

  exp_t expq[$];
  exp_t me;
  exp_t e;
  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // Monitor: one prediction per cycle, compared mid-cycle.
  always @(negedge clk) begin
    if (cyc >= 2) begin
      if (expq.size() == 0) begin
        cmp("expectation_present", 32'(expq.size()), 32'd1);
      end else begin
        e = expq.pop_front();
        cmp("grant", 32'(grant), 32'(e.grant));
        cmp("done", 32'(done), 32'(e.done));
        cmp("tx_data_en", 32'(tx_data_en), 32'(e.en));
        cmp("busy", 32'(busy), 32'(e.busy));
        cmp("tx_timeout", 32'(tx_timeout), 32'(e.tmo));
        if (e.chk_data) cmp("tx_data_in", 32'(tx_data_in), 32'(e.data));
      end
    end
  end

  // Reference model state
  int         m_ptr = 0;
  int         m_owner = 0;
  int         m_wait_from = 0;
  int         m_elig = 0;
  bit         m_xfer = 1'b0;
  logic [7:0] m_byte = 8'h00;
  int         rst_pulses = 0;
  int         c;
  int         w;
  bit         fin;
  bit         tmo;

  initial begin
    repeat (NCYC) begin
      @(posedge clk);
      #1;
      c = cyc;
      // Stimulus for cycle c
      if (c <= 3) begin
        rst_n = 1'b0;
      end else if (m_xfer && c >= m_wait_from && rst_pulses < 4 && $urandom_range(0, 29) == 0) begin
        rst_n = 1'b0;
        rst_pulses++;
      end else begin
        rst_n = 1'b1;
      end
      for (int i = 0; i < N; i++) begin
        if (grant[i]) begin
          req[i] = 1'b0;
        end else if (!req[i]) begin
          if ($urandom_range(0, 2) == 0) begin
            req[i] = 1'b1;
            req_data[8*i +: 8] = 8'($urandom);
          end
        end else if ($urandom_range(0, 39) == 0) begin
          req[i] = 1'b0;
        end
      end
      tx_finish = ($urandom_range(0, 3) == 0);

      // Model: predict outputs of cycle c+1
      me = '{default: '0};
      if (!rst_n) begin
        m_xfer   = 1'b0;
        m_ptr    = 0;
        m_elig   = c + 1;
        me.chk_data = 1'b1;
        me.data     = 8'h00;
      end else if (m_xfer) begin
        fin = tx_finish && (c >= m_wait_from);
        tmo = 1'b0;
`ifdef TX_TIMEOUT_EN
        if (!fin && c == m_wait_from + TMO - 1) tmo = 1'b1;
`endif
        me.chk_data = 1'b1;
        me.data     = m_byte;
        if (fin || tmo) begin
          me.done = N'(1 << m_owner);
          me.tmo  = tmo;
          me.busy = (GAP > 0);
          m_ptr   = (m_owner + 1) % N;
          m_xfer  = 1'b0;
          m_elig  = (GAP == 0) ? c + 1 : c + GAP + 2;
        end else begin
          me.busy = 1'b1;
        end
      end else if (c >= m_elig && req != '0) begin
        w = -1;
        for (int k = 0; k < N; k++) begin
          if (w < 0 && req[(m_ptr + k) % N]) w = (m_ptr + k) % N;
        end
        m_owner     = w;
        m_byte      = req_data[8*w +: 8];
        m_xfer      = 1'b1;
        m_wait_from = c + 2;
        me.grant    = N'(1 << w);
        me.en       = 1'b1;
        me.busy     = 1'b1;
        me.chk_data = 1'b1;
        me.data     = m_byte;
      end else begin
        me.busy = (c + 1 < m_elig);
      end
      expq.push_back(me);
    end
    @(posedge clk);
    @(negedge clk);
    #1;
    cmp("queue_drained", 32'(expq.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
